// File: rtl/hub75_color_rx.sv
// hub75_color_rx -- HUB75 receive-side row capture (panel emulator / loopback checker).
//
// Samples the HUB75 shift clock, per-segment RGB lines and latch enable. It
// rebuilds each shifted row of hpixel_p pixels per segment, and on the latch
// rising edge presents the row as a parallel snapshot with a one-cycle valid
// pulse.
//
// Optional feature macro: HUB75_RX_SYNC_EN
//   When defined, every input line gets a 2-flop synchronizer, which adds 2
//   cycles of latency. When undefined, the inputs must already be in the clk
//   domain.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   i_serial_clk         shift clock (data captured on its rise)
//   i_red/green/blue     [segments_p] data bit per segment
//   i_latch_en           rising edge commits the row
//   i_clr_err            clears o_len_err (a commit that sets it wins)
//   o_row_valid          one-cycle pulse per commit
//   o_row_red/green/blue [segments_p][hpixel_p] committed rows, bit 0 = first shifted
//   o_bit_cnt            bits shifted since last commit (saturates at hpixel_p)
//   o_row_cnt            committed row count (wraps)
//   o_len_err            sticky: a commit happened with a wrong length or overrun

// Per-segment working shift registers for R, G and B (index 0 = red).
module hub75_color_rx_lane #(
  parameter int hpixel_p = 64,
  parameter int cnt_wd_p = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     shift,
  input  logic                     ovf,
  input  logic                     commit,
  input  logic [cnt_wd_p-1:0]      idx,
  input  logic [2:0]               din,
  output logic [2:0][hpixel_p-1:0] nxt
);
  logic [2:0][hpixel_p-1:0] w;

  // nxt already includes a shift in the same cycle, so a commit sees that bit.
  always_comb begin
    nxt = w;
    if (shift) begin
      for (int c = 0; c < 3; c++) begin
        if (ovf) begin
          nxt[c] = {din[c], w[c][hpixel_p-1:1]};
        end else begin
          for (int i = 0; i < hpixel_p; i++)
            if (idx == cnt_wd_p'(i)) nxt[c][i] = din[c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      w <= '0;
    else if (commit) w <= '0;
    else             w <= nxt;
  end
endmodule

module hub75_color_rx #(
  parameter  int hpixel_p   = 64,
  parameter  int segments_p = 2,
  localparam int cnt_wd_p   = $clog2(hpixel_p+1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_serial_clk,
  input  logic [segments_p-1:0]                i_red,
  input  logic [segments_p-1:0]                i_green,
  input  logic [segments_p-1:0]                i_blue,
  input  logic                                 i_latch_en,
  input  logic                                 i_clr_err,
  output logic                                 o_row_valid,
  output logic [segments_p-1:0][hpixel_p-1:0]  o_row_red,
  output logic [segments_p-1:0][hpixel_p-1:0]  o_row_green,
  output logic [segments_p-1:0][hpixel_p-1:0]  o_row_blue,
  output logic [cnt_wd_p-1:0]                  o_bit_cnt,
  output logic [15:0]                          o_row_cnt,
  output logic                                 o_len_err
);
  localparam int IW = 3 + 3*segments_p;

  logic [IW-1:0] in_vec, s_vec;
  assign in_vec = {i_serial_clk, i_latch_en, i_clr_err, i_red, i_green, i_blue};

`ifdef HUB75_RX_SYNC_EN
  logic [IW-1:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_vec;
      sync2 <= sync1;
    end
  end
  assign s_vec = sync2;
`else
  assign s_vec = in_vec;
`endif

  logic                  s_sclk, s_latch, s_clr;
  logic [segments_p-1:0] s_red, s_green, s_blue;
  assign {s_sclk, s_latch, s_clr, s_red, s_green, s_blue} = s_vec;

  logic sclk_q, latch_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      sclk_q  <= s_sclk;
      latch_q <= s_latch;
    end
  end

  logic sclk_rise, latch_rise, shift, ovf, overrun, overrun_nxt;
  logic [cnt_wd_p-1:0] cnt_nxt;

  assign sclk_rise  = s_sclk & ~sclk_q;
  assign latch_rise = s_latch & ~latch_q;
  // Only a latch that was already high blocks a shift. A shift coinciding
  // with the latch rise is kept, so the committed row includes that bit.
  assign shift       = sclk_rise & ~(s_latch & latch_q);
  assign ovf         = (o_bit_cnt == cnt_wd_p'(hpixel_p));
  assign cnt_nxt     = (shift && !ovf) ? o_bit_cnt + 1'b1 : o_bit_cnt;
  assign overrun_nxt = overrun | (shift & ovf);

  logic [segments_p-1:0][2:0][hpixel_p-1:0] lane_nxt;

  for (genvar s = 0; s < segments_p; s++) begin : g_lane
    hub75_color_rx_lane #(.hpixel_p(hpixel_p), .cnt_wd_p(cnt_wd_p)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .shift  (shift),
      .ovf    (ovf),
      .commit (latch_rise),
      .idx    (o_bit_cnt),
      .din    ({s_blue[s], s_green[s], s_red[s]}),
      .nxt    (lane_nxt[s])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_row_valid <= 1'b0;
      o_row_red   <= '0;
      o_row_green <= '0;
      o_row_blue  <= '0;
      o_bit_cnt   <= '0;
      o_row_cnt   <= '0;
      o_len_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      o_row_valid <= latch_rise;
      if (latch_rise) begin
        for (int s = 0; s < segments_p; s++) begin
          o_row_red[s]   <= lane_nxt[s][0];
          o_row_green[s] <= lane_nxt[s][1];
          o_row_blue[s]  <= lane_nxt[s][2];
        end
        o_row_cnt <= o_row_cnt + 16'd1;
        o_bit_cnt <= '0;
        overrun   <= 1'b0;
        if (cnt_nxt != cnt_wd_p'(hpixel_p) || overrun_nxt) o_len_err <= 1'b1;
        else if (s_clr)                                    o_len_err <= 1'b0;
      end else begin
        o_bit_cnt <= cnt_nxt;
        overrun   <= overrun_nxt;
        if (s_clr) o_len_err <= 1'b0;
      end
    end
  end
endmodule
